// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM states,
// and the index-counter width helper.
package seq_add_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-nibble build still needs a one-bit index register.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_nibble_adder.sv
// Purely combinational 4-bit ripple adder; one instance is shared across all
// cycles of a wide addition.
module nibble_adder
    import seq_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a4,
    input  logic [NIBBLE_W-1:0] b4,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s4,
    output logic                co
);

    logic w_carry;

    always_comb begin
        w_carry = ci;
        s4      = '0;
        for (int unsigned i = 0; i < NIBBLE_W; i++) begin
            s4[i]   = a4[i] ^ b4[i] ^ w_carry;
            w_carry = (a4[i] & b4[i]) | (w_carry & (a4[i] ^ b4[i]));
        end
        co = w_carry;
    end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial wide adder: one shared 4-bit adder, LSB nibble first, carry
// held in a register between cycles. Optional ovf port: SEQ_ADD_OVF_EN.
module nibble_serial_adder_ctrl
    import seq_add_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NIBBLE_W*NIBBLES-1:0]   a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   b,
    input  logic                          cin,
    output logic                          busy,
    output logic                          done,
    output logic [NIBBLE_W*NIBBLES-1:0]   sum,
    output logic                          cout
`ifdef SEQ_ADD_OVF_EN
    ,
    output logic                          ovf
`endif
);

    localparam int unsigned W  = NIBBLE_W * NIBBLES;
    localparam int unsigned IW = idx_width(NIBBLES);

    state_t             r_state;
    logic [IW-1:0]      r_idx;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_carry;
    logic [W-1:0]       r_res;
    logic [W-1:0]       r_sum;
    logic               r_cout;
    logic               r_busy;
    logic               r_done;
`ifdef SEQ_ADD_OVF_EN
    logic               r_ovf;
`endif

    logic [NIBBLE_W-1:0] w_a4;
    logic [NIBBLE_W-1:0] w_b4;
    logic [NIBBLE_W-1:0] w_s4;
    logic                w_co;
    logic [W-1:0]        w_res_next;
    logic                w_last;

    // Operand slice selected by the running nibble index.
    always_comb begin
        w_a4 = '0;
        w_b4 = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (r_idx == IW'(i)) begin
                w_a4 = r_a[i*NIBBLE_W +: NIBBLE_W];
                w_b4 = r_b[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_adder u_nibble_adder (
        .a4 (w_a4),
        .b4 (w_b4),
        .ci (r_carry),
        .s4 (w_s4),
        .co (w_co)
    );

    // Result with the current nibble merged in, so the final edge can publish
    // the fully assembled word directly to sum.
    always_comb begin
        w_res_next = r_res;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (r_idx == IW'(i)) begin
                w_res_next[i*NIBBLE_W +: NIBBLE_W] = w_s4;
            end
        end
    end

    assign w_last = (r_idx == IW'(NIBBLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SEQ_ADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ADD;
                    end
                end

                ADD: begin
                    r_res   <= w_res_next;
                    r_carry <= w_co;
                    if (w_last) begin
                        r_idx   <= '0;
                        r_sum   <= w_res_next;
                        r_cout  <= w_co;
`ifdef SEQ_ADD_OVF_EN
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) &&
                                   (w_res_next[W-1] != r_a[W-1]);
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx + IW'(1);
                    end
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
`ifdef SEQ_ADD_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: directed table, random ops against an
// arithmetic model, held-start throughput, mid-ADD reset, and NIBBLES=1.
module tb_nibble_serial_adder_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start, cin;
    logic [15:0] a, b;
    logic        busy, done, cout;
    logic [15:0] sum;
    logic        start1, cin1;
    logic [3:0]  a1, b1;
    logic        busy1, done1, cout1;
    logic [3:0]  sum1;
`ifdef SEQ_ADD_OVF_EN
    logic        ovf, ovf1;
`endif

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SEQ_ADD_OVF_EN
        , .ovf(ovf)
`endif
    );

    nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SEQ_ADD_OVF_EN
        , .ovf(ovf1)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + 17'(c);
    endfunction

    function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y, input logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (s > 32767) || (s < -32768);
    endfunction

    function automatic logic ref_ovf4(input logic [3:0] x, input logic [3:0] y, input logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (s > 7) || (s < -8);
    endfunction

    // Protocol monitor: done is a single-cycle pulse and never overlaps busy.
    logic prev_done = 1'b0, prev_done1 = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev_done  = 1'b0;
            prev_done1 = 1'b0;
        end else begin
            check("protocol_w4", {30'd0, done & prev_done, busy & done}, 32'd0);
            check("protocol_w1", {30'd0, done1 & prev_done1, busy1 & done1}, 32'd0);
            prev_done  = done;
            prev_done1 = done1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    logic [15:0] exp_prev;

    task automatic run_add(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                           input bit scramble, output logic [15:0] rs, output logic rc,
                           output int nbusy, output int lat);
        bit found;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0; lat = 1; found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            if (busy) begin
                nbusy++;
                check("sum_hold", 32'(sum), 32'(exp_prev));
            end
            if (scramble) begin
                a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        if (!found) check("done_timeout", 32'd0, 32'd1);
        rs = sum;
        rc = cout;
    endtask

    task automatic run_add1(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc,
                            output logic [3:0] rs, output logic rc, output int nbusy, output int lat);
        bit found;
        @(negedge clk);
        a1 = ta; b1 = tb_v; cin1 = tc; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        nbusy = 0; lat = 1; found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done1) begin
                found = 1'b1;
                break;
            end
            if (busy1) nbusy++;
            @(negedge clk);
            lat++;
        end
        if (!found) check("done1_timeout", 32'd0, 32'd1);
        rs = sum1;
        rc = cout1;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [15:0] rs;
        logic        rc;
        logic [3:0]  rs1;
        logic        rc1;
        logic [16:0] m;
        logic [15:0] va[12];
        logic [15:0] vb[12];
        int          nb, lt, ndone, t1, t2;
        logic [15:0] s1, s2;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{16'h0F0F, 16'hF0F1, 1'b0, 16'h0000, 1'b1, 1'b0};

        reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
`ifdef SEQ_ADD_OVF_EN
        check("rst_ovf",  32'(ovf),  32'd0);
`endif
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("idle_no_done", 32'(done), 32'd0);
        end
        exp_prev = 16'h0000;

        for (int i = 0; i < 8; i++) begin
            run_add(vecs[i].a, vecs[i].b, vecs[i].cin, (i % 2) == 1, rs, rc, nb, lt);
            check("vec_sum",   32'(rs), 32'(vecs[i].sum));
            check("vec_cout",  32'(rc), 32'(vecs[i].cout));
            check("vec_busy",  32'(nb), 32'd4);
            check("vec_lat",   32'(lt), 32'd5);
`ifdef SEQ_ADD_OVF_EN
            check("vec_ovf",   32'(ovf), 32'(vecs[i].ovf));
`endif
            exp_prev = vecs[i].sum;
        end

        for (int i = 0; i < 30; i++) begin
            logic [15:0] ra, rb;
            logic        rcn;
            ra = 16'($urandom); rb = 16'($urandom); rcn = 1'($urandom);
            if (i % 5 == 0) ra = 16'hFFFF;
            m = ref_add(ra, rb, rcn);
            run_add(ra, rb, rcn, 1'b1, rs, rc, nb, lt);
            check("rnd_sum",  32'(rs), 32'(m[15:0]));
            check("rnd_cout", 32'(rc), 32'(m[16]));
            check("rnd_lat",  32'(lt), 32'd5);
`ifdef SEQ_ADD_OVF_EN
            check("rnd_ovf",  32'(ovf), 32'(ref_ovf(ra, rb, rcn)));
`endif
            exp_prev = m[15:0];
        end

        // start held high with fresh operands every cycle: accepts at t=0 and t=6 only
        for (int t = 0; t < 12; t++) begin
            va[t] = 16'($urandom);
            vb[t] = 16'($urandom);
        end
        ndone = 0; t1 = -1; t2 = -1; s1 = '0; s2 = '0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (t > 0 && done) begin
                ndone++;
                if (t1 < 0) begin t1 = t; s1 = sum; end
                else begin t2 = t; s2 = sum; end
            end
            cin = 1'b0;
            if (t < 11) begin
                a = va[t]; b = vb[t]; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        m = ref_add(va[0], vb[0], 1'b0);
        check("held_sum1", 32'(s1), 32'(m[15:0]));
        m = ref_add(va[6], vb[6], 1'b0);
        check("held_sum2", 32'(s2), 32'(m[15:0]));
        check("held_ndone", 32'(ndone), 32'd2);
        check("held_t1", 32'(t1), 32'd5);
        check("held_gap", 32'(t2 - t1), 32'd6);
        exp_prev = m[15:0];

        // reset during the 2nd ADD cycle aborts the add
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum",  32'(sum),  32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
            check("abort_sum_held", 32'(sum), 32'd0);
        end
        exp_prev = 16'h0000;
        run_add(16'h1234, 16'h4321, 1'b0, 1'b0, rs, rc, nb, lt);
        check("after_abort_sum", 32'(rs), 32'h5555);
        check("after_abort_lat", 32'(lt), 32'd5);

        // NIBBLES=1 instance
        run_add1(4'hF, 4'h1, 1'b0, rs1, rc1, nb, lt);
        check("n1_sum",  32'(rs1), 32'h0);
        check("n1_cout", 32'(rc1), 32'd1);
        check("n1_busy", 32'(nb),  32'd1);
        check("n1_lat",  32'(lt),  32'd2);
        for (int i = 0; i < 10; i++) begin
            logic [3:0] xa, xb;
            logic       xc;
            logic [4:0] m4;
            xa = 4'($urandom); xb = 4'($urandom); xc = 1'($urandom);
            m4 = {1'b0, xa} + {1'b0, xb} + 5'(xc);
            run_add1(xa, xb, xc, rs1, rc1, nb, lt);
            check("n1_rnd_sum",  32'(rs1), 32'(m4[3:0]));
            check("n1_rnd_cout", 32'(rc1), 32'(m4[4]));
`ifdef SEQ_ADD_OVF_EN
            check("n1_rnd_ovf",  32'(ovf1), 32'(ref_ovf4(xa, xb, xc)));
`endif
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
